pixout_fifo_bridge: RTL and testbench
=====================================

Name: pixout_fifo_bridge

Overview:
- Parametrised successor to the single-register 24-bit pixel PIO export.
- Nios-side Avalon-MM slave pushes pixels into an internal show-ahead FIFO.
- Pixels drain to the video/blitter side over a valid/ready stream.
- Adds a hardware fill mode (one write replicated N+1 times) and a sticky underflow flag, so the CPU no longer bit-bangs every pixel.

Parameters:
- PIX_W, 24, pixel width in bits (1..32).
- DEPTH, 16, FIFO depth in entries; power of 2, at least 2.
- REP_W, 16, width of the fill repeat counter.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 REPEAT.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed read latency 1.
- avs_waitrequest  out  1  stall for DATA writes.
- pix_data  out  PIX_W  head-of-FIFO pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- irq  out  1  level interrupt, high while underflow flag set and irq_en=1.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, enable=0, irq_en=0, REPEAT=0, underflow=0.
  - Output reset values: avs_readdata=0, pix_valid=0, pix_data=0, irq=0, avs_waitrequest=0.
- FIFO: show-ahead, so pix_data is the head entry.
  - Level width $clog2(DEPTH+1).
  - Read and write pointers wrap modulo DEPTH.
- Stream side:
  - pix_valid = enable & ~empty.
  - Pop when pix_valid & pix_ready.
  - With enable=0 nothing pops; pix_ready is ignored.
- Push and pop in the same cycle: level unchanged.
  - This is allowed when not full.
  - When full, push is blocked even if a pop occurs that cycle; the writer retries the next cycle.
- DATA write (addr 0):
  - avs_waitrequest = write & addr==0 & (full | state==FILL), combinational.
  - When not stalled, writedata[PIX_W-1:0] is pushed.
  - If REPEAT==0, state stays IDLE.
  - If REPEAT!=0, the pixel is latched, the counter is loaded with REPEAT, and state goes IDLE→FILL.
- FILL state:
  - Pushes the latched pixel each cycle the FIFO is not full.
  - Decrements the counter on each push.
  - On the push with counter==1: state→IDLE and REPEAT auto-clears to 0.
  - Total pushes for one DATA write = REPEAT+1.
- STATUS read (addr 1):
  - bits [15:0] level, zero-extended.
  - bit16 full, bit17 empty, bit18 underflow, bit19 fill_busy.
- CONTROL (addr 2):
  - bit0 enable, bit1 irq_en: read/write.
  - bit2 flush: write-1 pulse. Empties the FIFO, aborts FILL (state→IDLE), clears REPEAT.
  - bit3 clr_underflow: write-1 pulse.
  - Pulse bits read as 0.
- REPEAT (addr 3): read/write, low REP_W bits; writes during FILL are ignored.
- Underflow flag:
  - Set when enable & pix_ready & empty & state!=FILL.
  - If set and clear happen in the same cycle, set wins.
- Flush with a simultaneous DATA write: flush wins and the write is dropped (no waitrequest).
- Reads and waitrequest:
  - Reads never stall.
  - Read data is registered one cycle after avs_read.
  - avs_readdata holds its last value otherwise.
- Writes to addresses other than DATA never stall.
- Pixel bits of writedata above PIX_W are ignored.

Decomposition:
- Package pixout_pkg: register address constants (ADDR_DATA..ADDR_REPEAT), STATUS/CONTROL bit-position constants, state enum {IDLE, FILL}.
- Sub-module pixout_sync_fifo:
  - parameters WIDTH, DEPTH;
  - ports push, pop, wdata, rdata, full, empty, level, flush;
  - show-ahead behaviour.
- Top level holds the register file, fill FSM and underflow logic.

Test Plan:
- Reset mid-FILL with REPEAT=100: assert reset_reset_n=0 at push 40 → pix_valid=0, STATUS reads 0x00020000 (empty only), REPEAT=0.
- Write 17 pixels 0x000001..0x000011, enable=0, DEPTH=16:
  - writes 1-16 complete; write 17 sees waitrequest=1;
  - set enable with pix_ready=1 → write 17 completes one cycle after the first pop;
  - sink sees 1..17 in order.
- REPEAT=20, DATA=0xFF8800, enable=1, pix_ready toggling 50% → exactly 21 beats of 0xFF8800; fill_busy falls after the last push; REPEAT reads 0.
- Mid-fill flush (REPEAT=30, flush after 5 pushes) → level=0 next cycle, state IDLE, no further pixels, next DATA write accepted immediately.
- enable=1, irq_en=1, empty, pix_ready=1 → underflow=1 and irq=1 next cycle.
  - clr_underflow written while pix_ready=1 → flag stays 1 (set wins).
  - With pix_ready=0, clearing drops irq.
- Steady state with a full FIFO, pix_ready=1 every cycle and a continuous DATA write stream → one pixel per cycle alternating, level stays DEPTH-1..DEPTH, no loss, no reordering (scoreboard).

Source files
------------

// File: rtl/pixout_pkg.sv
// Shared definitions for the pixel output FIFO bridge: register map,
// STATUS/CONTROL bit positions, fill FSM state type and the STATUS word packer.
package pixout_pkg;

    // Avalon-MM register map
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_REPEAT  = 2'd3;

    // STATUS bit positions (level occupies [15:0])
    localparam int ST_FULL_BIT      = 16;
    localparam int ST_EMPTY_BIT     = 17;
    localparam int ST_UNDERFLOW_BIT = 18;
    localparam int ST_FILL_BUSY_BIT = 19;

    // CONTROL bit positions
    localparam int CTL_ENABLE_BIT = 0;
    localparam int CTL_IRQ_EN_BIT = 1;
    localparam int CTL_FLUSH_BIT  = 2;
    localparam int CTL_CLR_UF_BIT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Pack the STATUS register word from its fields.
    function automatic logic [31:0] status_word(
        input logic [15:0] level,
        input logic        full,
        input logic        empty,
        input logic        underflow,
        input logic        fill_busy
    );
        return {12'd0, fill_busy, underflow, empty, full, level};
    endfunction

endpackage

// File: rtl/pixout_sync_fifo.sv
// Show-ahead synchronous FIFO.
// Ports: clk/rst_n clock and async active-low reset; flush empties the FIFO
// synchronously (wins over push/pop); push/wdata write when not full;
// pop advances the head when not empty; rdata is the head entry (0 when
// empty); full/empty/level report occupancy.
module pixout_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;

    // Occupancy flags and qualified push/pop
    always_comb begin
        full_s    = (level_r == LVL_W'(DEPTH));
        empty_s   = (level_r == LVL_W'(0));
        push_ok_s = push & ~full_s & ~flush;
        pop_ok_s  = pop & ~empty_s & ~flush;
        if (empty_s) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    // Storage array; data only, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and level; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/pixout_fifo_bridge.sv
// Avalon-MM pixel export bridge: CPU writes pixels into a show-ahead FIFO
// that drains over a valid/ready stream, with a hardware fill mode (one DATA
// write replicated REPEAT+1 times) and a sticky underflow interrupt.
// Ports: clk_clk/reset_reset_n clock and async active-low reset;
// avs_* Avalon-MM slave (read latency 1, waitrequest on stalled DATA writes);
// pix_data/pix_valid/pix_ready output stream; irq level interrupt.
module pixout_fifo_bridge
    import pixout_pkg::*;
#(
    parameter int PIX_W = 24,
    parameter int DEPTH = 16,
    parameter int REP_W = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    output logic             avs_waitrequest,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             irq
);

    localparam int LVL_W = $clog2(DEPTH+1);

    fill_state_e      state_r;
    fill_state_e      state_nxt_s;
    logic             enable_r;
    logic             irq_en_r;
    logic             underflow_r;
    logic [REP_W-1:0] repeat_r;
    logic [REP_W-1:0] count_r;
    logic [PIX_W-1:0] fill_pix_r;
    logic [31:0]      readdata_r;

    logic             data_wr_s;
    logic             ctl_wr_s;
    logic             rep_wr_s;
    logic             flush_s;
    logic             clr_uf_s;
    logic             wait_s;
    logic             data_push_s;
    logic             fill_push_s;
    logic             push_s;
    logic [PIX_W-1:0] push_data_s;
    logic             pop_s;
    logic             uf_set_s;
    logic [31:0]      rd_mux_s;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] fifo_level_s;
    logic [PIX_W-1:0] fifo_rdata_s;

    // High write-data bits beyond the widest field are intentionally ignored
    logic             unused_wdata_s;
    assign unused_wdata_s = &{1'b0, avs_writedata};

    pixout_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .flush (flush_s),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_data_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Bus decode, stall, push/pop qualification and underflow detection
    always_comb begin
        data_wr_s   = avs_write & (avs_address == ADDR_DATA);
        ctl_wr_s    = avs_write & (avs_address == ADDR_CONTROL);
        rep_wr_s    = avs_write & (avs_address == ADDR_REPEAT);
        flush_s     = ctl_wr_s & avs_writedata[CTL_FLUSH_BIT];
        clr_uf_s    = ctl_wr_s & avs_writedata[CTL_CLR_UF_BIT];
        wait_s      = data_wr_s & (fifo_full_s | (state_r == FILL));
        // Full blocks a push even when a pop frees a slot in the same cycle
        data_push_s = data_wr_s & ~wait_s & ~flush_s;
        fill_push_s = (state_r == FILL) & ~fifo_full_s & ~flush_s;
        push_s      = data_push_s | fill_push_s;
        if (state_r == FILL) begin
            push_data_s = fill_pix_r;
        end else begin
            push_data_s = avs_writedata[PIX_W-1:0];
        end
        pop_s    = enable_r & ~fifo_empty_s & pix_ready;
        // The sink asking while a fill is still producing is not an underflow
        uf_set_s = enable_r & pix_ready & fifo_empty_s & (state_r != FILL);
    end

    // Fill FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_push_s && (repeat_r != REP_W'(0))) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (flush_s) begin
                    state_nxt_s = IDLE;
                end else if (fill_push_s && (count_r == REP_W'(1))) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Fill FSM state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // CONTROL read/write bits
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            enable_r <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (ctl_wr_s) begin
            enable_r <= avs_writedata[CTL_ENABLE_BIT];
            irq_en_r <= avs_writedata[CTL_IRQ_EN_BIT];
        end
    end

    // REPEAT register: frozen during FILL, cleared by flush or fill completion
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            repeat_r <= REP_W'(0);
        end else if (flush_s) begin
            repeat_r <= REP_W'(0);
        end else if (fill_push_s && (count_r == REP_W'(1))) begin
            repeat_r <= REP_W'(0);
        end else if (rep_wr_s && (state_r != FILL)) begin
            repeat_r <= avs_writedata[REP_W-1:0];
        end
    end

    // Fill counter and latched fill pixel
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            count_r    <= REP_W'(0);
            fill_pix_r <= {PIX_W{1'b0}};
        end else if (data_push_s && (repeat_r != REP_W'(0))) begin
            count_r    <= repeat_r;
            fill_pix_r <= avs_writedata[PIX_W-1:0];
        end else if (fill_push_s) begin
            count_r <= count_r - REP_W'(1);
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            underflow_r <= 1'b0;
        end else if (uf_set_s) begin
            underflow_r <= 1'b1;
        end else if (clr_uf_s) begin
            underflow_r <= 1'b0;
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            ADDR_STATUS:  rd_mux_s = status_word(16'(fifo_level_s), fifo_full_s,
                                                 fifo_empty_s, underflow_r,
                                                 (state_r == FILL));
            ADDR_CONTROL: rd_mux_s = 32'({irq_en_r, enable_r});
            ADDR_REPEAT:  rd_mux_s = 32'(repeat_r);
            default:      rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_r <= 32'd0;
        end else if (avs_read) begin
            readdata_r <= rd_mux_s;
        end
    end

    assign avs_readdata    = readdata_r;
    assign avs_waitrequest = wait_s;
    assign pix_data        = fifo_rdata_s;
    assign pix_valid       = enable_r & ~fifo_empty_s;
    assign irq             = underflow_r & irq_en_r;

endmodule

// File: tb/tb_pixout_fifo_bridge.sv
// Self-checking bench for pixout_fifo_bridge: a table of register accesses
// with hand-computed read values, then directed multi-cycle sequences for
// back-pressure, fill mode, flush, underflow/irq, streaming and reset.
module tb_pixout_fifo_bridge;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_REP  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    pixout_fifo_bridge dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sink monitor: records each beat that will be accepted at the next rising edge
    always @(negedge clk) begin
        #2;
        if (rst_n && pix_valid && pix_ready) q.push_back(pix_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int waits);
        int n;
        n = 0;
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        #1;
        while (avs_waitrequest && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL bus_write_timeout: addr %0d still stalled after %0d cycles", a, n);
        end
        @(negedge clk);
        avs_write = 1'b0;
        waits = n;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_beats(input int want, input int budget, input string name);
        int n;
        n = 0;
        while (q.size() < want && n < budget) begin
            @(negedge clk); n++;
        end
        if (q.size() < want) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", name, q.size(), want);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int w;
        int tw;
        int bad;
        int idx;
        int n;

        rst_n = 1'b0; avs_address = 2'd0; avs_write = 1'b0; avs_writedata = 32'd0;
        avs_read = 1'b0; pix_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register table
        vecs[0]  = '{1'b0, A_STAT, 32'd0,          32'h0002_0000};
        vecs[1]  = '{1'b0, A_CTRL, 32'd0,          32'h0000_0000};
        vecs[2]  = '{1'b0, A_REP,  32'd0,          32'h0000_0000};
        vecs[3]  = '{1'b1, A_REP,  32'h0001_2345,  32'd0};
        vecs[4]  = '{1'b0, A_REP,  32'd0,          32'h0000_2345};
        vecs[5]  = '{1'b1, A_REP,  32'd0,          32'd0};
        vecs[6]  = '{1'b0, A_REP,  32'd0,          32'h0000_0000};
        vecs[7]  = '{1'b1, A_CTRL, 32'h0000_0002,  32'd0};
        vecs[8]  = '{1'b0, A_CTRL, 32'd0,          32'h0000_0002};
        vecs[9]  = '{1'b1, A_CTRL, 32'h0000_000C,  32'd0};
        vecs[10] = '{1'b0, A_CTRL, 32'd0,          32'h0000_0000};
        vecs[11] = '{1'b1, A_DATA, 32'hAB12_3456,  32'd0};
        vecs[12] = '{1'b0, A_STAT, 32'd0,          32'h0000_0001};
        vecs[13] = '{1'b1, A_CTRL, 32'h0000_0004,  32'd0};
        vecs[14] = '{1'b0, A_STAT, 32'd0,          32'h0002_0000};
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data, w);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end

        // Back-pressure: 16 fit, the 17th stalls until one cycle after the first pop
        q.delete(); tw = 0;
        for (int i = 1; i <= 16; i++) begin
            bus_write(A_DATA, 32'(i), w);
            tw += w;
        end
        check("a_no_stall_1_16", 32'(tw), 32'd0);
        bus_read(A_STAT, rd);
        check("a_status_full", rd, 32'h0001_0010);
        bus_write(A_CTRL, 32'h1, w);
        check("a_valid", 32'(pix_valid), 32'd1);
        check("a_head", 32'(pix_data), 32'h0000_0001);
        @(negedge clk);
        avs_address = A_DATA; avs_writedata = 32'h11; avs_write = 1'b1;
        #1; check("a_stall17", 32'(avs_waitrequest), 32'd1);
        @(negedge clk); #1; check("a_stall17_hold", 32'(avs_waitrequest), 32'd1);
        @(negedge clk); pix_ready = 1'b1;
        #1; check("a_stall_pop_cycle", 32'(avs_waitrequest), 32'd1);
        @(negedge clk); #1; check("a_accept_after_pop", 32'(avs_waitrequest), 32'd0);
        @(negedge clk); avs_write = 1'b0;
        wait_beats(17, 100, "a_drain");
        check("a_beats", 32'(q.size()), 32'd17);
        bad = 0;
        for (int i = 0; i < q.size(); i++) if (q[i] !== 24'(i + 1)) bad++;
        check("a_order", 32'(bad), 32'd0);
        pix_ready = 1'b0;
        bus_write(A_CTRL, 32'h8, w);

        // Fill mode with a 50% ready pattern
        q.delete();
        bus_write(A_REP, 32'd20, w);
        bus_write(A_CTRL, 32'h1, w);
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    @(negedge clk); pix_ready = ~pix_ready;
                end
            end
            begin
                bus_write(A_DATA, 32'h00FF_8800, w);
                bus_read(A_STAT, rd);
                check("b_fill_busy", (rd >> 19) & 32'd1, 32'd1);
            end
        join
        pix_ready = 1'b0;
        check("b_beats", 32'(q.size()), 32'd21);
        bad = 0;
        for (int i = 0; i < q.size(); i++) if (q[i] !== 24'hFF8800) bad++;
        check("b_values", 32'(bad), 32'd0);
        bus_read(A_STAT, rd);
        check("b_status_done", rd & 32'hFFFB_FFFF, 32'h0002_0000);
        bus_read(A_REP, rd);
        check("b_repeat_cleared", rd, 32'd0);
        bus_write(A_CTRL, 32'h8, w);

        // Flush in the middle of a fill
        q.delete();
        bus_write(A_REP, 32'd30, w);
        bus_write(A_DATA, 32'h0000_AA55, w);
        repeat (4) @(negedge clk);
        bus_read(A_STAT, rd);
        check("c_busy_before_flush", (rd >> 19) & 32'd1, 32'd1);
        bus_write(A_CTRL, 32'h4, w);
        bus_read(A_STAT, rd);
        check("c_status_after_flush", rd, 32'h0002_0000);
        bus_read(A_REP, rd);
        check("c_repeat_after_flush", rd, 32'd0);
        repeat (10) @(negedge clk);
        bus_read(A_STAT, rd);
        check("c_no_more_pushes", rd, 32'h0002_0000);
        bus_write(A_DATA, 32'h0000_0123, w);
        check("c_write_immediate", 32'(w), 32'd0);
        bus_read(A_STAT, rd);
        check("c_level_one", rd, 32'h0000_0001);
        check("c_head", 32'(pix_data), 32'h0000_0123);
        bus_write(A_CTRL, 32'h4, w);

        // Underflow, irq, set-beats-clear
        pix_ready = 1'b1;
        bus_write(A_CTRL, 32'h3, w);
        #1; check("d_irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk); #1;
        check("d_irq_set", 32'(irq), 32'd1);
        bus_read(A_STAT, rd);
        check("d_status_uf", rd, 32'h0006_0000);
        bus_write(A_CTRL, 32'hB, w);
        #1; check("d_irq_set_wins", 32'(irq), 32'd1);
        bus_read(A_STAT, rd);
        check("d_status_set_wins", rd, 32'h0006_0000);
        pix_ready = 1'b0;
        bus_write(A_CTRL, 32'hB, w);
        #1; check("d_irq_cleared", 32'(irq), 32'd0);
        bus_read(A_STAT, rd);
        check("d_status_cleared", rd, 32'h0002_0000);

        // Streaming with a full FIFO: one pixel in and one out per cycle
        q.delete();
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'h100 + 32'(i), w);
        idx = 16;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            avs_address = A_DATA; avs_writedata = 32'h100 + 32'(idx);
            avs_write = 1'b1; pix_ready = 1'b1;
            #1;
            if (!avs_waitrequest) idx++;
        end
        @(negedge clk);
        avs_write = 1'b0; pix_ready = 1'b0;
        check("e_accepted", 32'(idx - 16), 32'd39);
        bus_read(A_STAT, rd);
        check("e_level", rd, 32'h0000_000F);
        pix_ready = 1'b1;
        wait_beats(55, 200, "e_drain");
        pix_ready = 1'b0;
        check("e_beats", 32'(q.size()), 32'd55);
        bad = 0;
        for (int i = 0; i < q.size(); i++) if (q[i] !== 24'(32'h100 + 32'(i))) bad++;
        check("e_order", 32'(bad), 32'd0);

        // Reset in the middle of a long fill
        q.delete();
        bus_write(A_REP, 32'd100, w);
        pix_ready = 1'b1;
        bus_write(A_DATA, 32'h0000_00C0, w);
        n = 0;
        while (q.size() < 40 && n < 300) begin
            @(negedge clk); n++;
        end
        check("f_reached_40", 32'(q.size() >= 40), 32'd1);
        rst_n = 1'b0;
        #1;
        check("f_valid_in_reset", 32'(pix_valid), 32'd0);
        check("f_readdata_in_reset", avs_readdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_STAT, rd);
        check("f_status", rd, 32'h0002_0000);
        bus_read(A_REP, rd);
        check("f_repeat", rd, 32'd0);
        bus_read(A_CTRL, rd);
        check("f_control", rd, 32'd0);
        check("f_valid_after", 32'(pix_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
